// File: rtl/tcm_stream_loader.sv
// Boot loader: turns a byte stream of load frames into 32-bit writes on the core ext port and
// holds the core in reset until an end frame. Optional macro LOADER_CHECKSUM_EN adds a per-frame XOR byte.
module tcm_stream_loader #(
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned ACK_TO = 255,
  parameter int unsigned CNT_W  = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid_i,
  input  logic [7:0]       s_data_i,
  output logic             s_ready_o,
  output logic             ext_req_o,
  output logic             ext_we_o,
  output logic [31:0]      ext_addr_o,
  output logic [31:0]      ext_wdata_o,
  input  logic             ext_ack_i,
  input  logic             ext_error_i,
  output logic             core_rst_no,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] words_o
);

  localparam int unsigned     LEN_B    = LEN_W / 8;
  localparam int unsigned     TO_W     = $clog2(ACK_TO + 1);
  localparam logic [1:0]      LEN_LAST = 2'(LEN_B - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(ACK_TO - 1);

  typedef enum logic [2:0] {
    S_ADDR,
    S_LEN,
    S_DATA,
    S_WR,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_BOOT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              s_ready_q, s_ready_d;
  logic              ext_req_q, ext_req_d;
  logic [31:0]       ext_addr_q, ext_addr_d;
  logic [31:0]       ext_wdata_q, ext_wdata_d;
  logic              core_rst_q, core_rst_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  words_q, words_d;

  logic              fire_c;
  logic              resp_c;
  logic              timeout_c;
  logic [31:0]       word_c;
  logic [LEN_W-1:0]  len_c;

  assign fire_c    = s_valid_i & s_ready_q;
  assign resp_c    = ext_ack_i | ext_error_i;
  assign timeout_c = (to_cnt_q == TO_LAST);
  assign len_c     = word_c[LEN_W-1:0];

  // Current byte dropped into its little-endian lane of the assembly word
  always_comb begin
    word_c = asm_q;
    case (byte_cnt_q)
      2'd0: word_c[7:0]   = s_data_i;
      2'd1: word_c[15:8]  = s_data_i;
      2'd2: word_c[23:16] = s_data_i;
      2'd3: word_c[31:24] = s_data_i;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  // Running XOR over header and payload bytes, restarted by the first address byte
  always_comb begin
    csum_d = csum_q;
    if (fire_c && (state_q == S_ADDR) && (byte_cnt_q == 2'd0)) begin
      csum_d = s_data_i;
    end else if (fire_c && ((state_q == S_ADDR) || (state_q == S_LEN) || (state_q == S_DATA))) begin
      csum_d = csum_q ^ s_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= 8'h00;
    else        csum_q <= csum_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ADDR;
      byte_cnt_q  <= 2'd0;
      asm_q       <= 32'h0;
      rem_q       <= '0;
      to_cnt_q    <= '0;
      s_ready_q   <= 1'b0;
      ext_req_q   <= 1'b0;
      ext_addr_q  <= 32'h0;
      ext_wdata_q <= 32'h0;
      core_rst_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      rem_q       <= rem_d;
      to_cnt_q    <= to_cnt_d;
      s_ready_q   <= s_ready_d;
      ext_req_q   <= ext_req_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      core_rst_q  <= core_rst_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      words_q     <= words_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    rem_d       = rem_q;
    to_cnt_d    = to_cnt_q;
    s_ready_d   = 1'b0;
    ext_req_d   = ext_req_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    core_rst_d  = core_rst_q;
    busy_d      = busy_q;
    err_d       = err_q;
    words_d     = words_q;

    case (state_q)
      S_ADDR: begin
        if (fire_c) begin
          asm_d  = word_c;
          busy_d = 1'b1;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            // Misaligned base is flagged but the frame still lands on the aligned word
            ext_addr_d = {word_c[31:2], 2'b00};
            if (word_c[1:0] != 2'b00) err_d = 1'b1;
            state_d    = S_LEN;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      S_LEN: begin
        if (fire_c) begin
          asm_d = word_c;
          if (byte_cnt_q == LEN_LAST) begin
            byte_cnt_d = 2'd0;
            rem_d      = len_c;
            if (len_c == '0) begin
              state_d    = S_BOOT;
              busy_d     = 1'b0;
              core_rst_d = ~err_q;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      S_DATA: begin
        if (fire_c) begin
          asm_d = word_c;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d  = 2'd0;
            ext_wdata_d = word_c;
            ext_req_d   = 1'b1;
            to_cnt_d    = '0;
            state_d     = S_WR;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      S_WR: begin
        if (resp_c || timeout_c) begin
          ext_req_d  = 1'b0;
          ext_addr_d = ext_addr_q + 32'd4;
          rem_d      = rem_q - LEN_W'(1);
          if (ext_ack_i && !ext_error_i) begin
            if (~&words_q) words_d = words_q + CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
          if (rem_q == LEN_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_ADDR;
            busy_d  = 1'b0;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (fire_c) begin
          if (s_data_i != csum_q) err_d = 1'b1;
          state_d = S_ADDR;
          busy_d  = 1'b0;
        end
      end
`endif

      S_BOOT: state_d = S_DONE;

      S_DONE: state_d = S_DONE;

      default: state_d = S_ADDR;
    endcase

    // Ready is registered, so it follows the state being entered
    case (state_d)
      S_ADDR, S_LEN, S_DATA: s_ready_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: s_ready_d = 1'b1;
`endif
      default: s_ready_d = 1'b0;
    endcase
  end

  assign s_ready_o   = s_ready_q;
  assign ext_req_o   = ext_req_q;
  assign ext_we_o    = ext_req_q;
  assign ext_addr_o  = ext_addr_q;
  assign ext_wdata_o = ext_wdata_q;
  assign core_rst_no = core_rst_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign words_o     = words_q;

endmodule
